// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types and helpers for fetch-side branch prediction:
//   - ctr_e         : 2-bit saturating direction counter encoding
//   - btb_entry_t   : one branch target buffer entry
//   - ctr_next()    : saturating counter update, reusable by other predictors
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

   // Widest tag any legal configuration can need (IDX_W >= 1, 32-bit PC,
   // two byte-offset bits). Narrower tags are stored zero-extended.
   localparam int MAX_TAG_W = 29;

   typedef logic [MAX_TAG_W-1:0] btb_tag_t;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,  // strongly not taken
      CTR_WNT = 2'b01,  // weakly not taken
      CTR_WT  = 2'b10,  // weakly taken
      CTR_ST  = 2'b11   // strongly taken
   } ctr_e;

   typedef struct packed {
      logic        valid;
      btb_tag_t    tag;
      logic [31:0] target;
      ctr_e        ctr;
   } btb_entry_t;

   localparam btb_entry_t BTB_ENTRY_RESET = '{
      valid:  1'b0,
      tag:    '0,
      target: 32'h0000_0000,
      ctr:    CTR_WNT
   };

   // Move one step toward the observed direction, holding at either end.
   function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
      ctr_e nxt;
      nxt = ctr;
      if (taken) begin
         case (ctr)
            CTR_SNT: nxt = CTR_WNT;
            CTR_WNT: nxt = CTR_WT;
            CTR_WT:  nxt = CTR_ST;
            default: nxt = CTR_ST;
         endcase
      end else begin
         case (ctr)
            CTR_ST:  nxt = CTR_WT;
            CTR_WT:  nxt = CTR_WNT;
            CTR_WNT: nxt = CTR_SNT;
            default: nxt = CTR_SNT;
         endcase
      end
      return nxt;
   endfunction

endpackage : branch_predictor_pkg

// File: rtl/bpu_perf_counter.sv
// -----------------------------------------------------------------------------
// bpu_perf_counter
// Free-running 32-bit event counter with enable and synchronous clear.
// Wraps from 0xFFFFFFFF to 0; clear wins over enable.
//   clk      in   clock
//   clr_i    in   synchronous clear, active-high
//   en_i     in   count this cycle
//   count_o  out  registered count
// -----------------------------------------------------------------------------
module bpu_perf_counter (
   input  logic        clk,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   assign count_d = en_i ? count_q + 32'd1 : count_q;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         count_q <= 32'h0000_0000;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : bpu_perf_counter

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with 2-bit saturating counters. Predicts
// direction and target for the fetch PC combinationally, is trained by the
// resolved branch from EXE, and counts branches and mispredictions.
//   clk              in   clock
//   rst              in   synchronous reset, active-high
//   IF_PC            in   fetch PC to predict
//   IF_Hit           out  valid entry with matching tag
//   IF_PredTaken     out  hit and counter predicts taken
//   IF_PredTarget    out  stored target when predicted taken, else IF_PC + 4
//   EXE_Update       in   a branch resolved in EXE this cycle
//   EXE_PC           in   PC of the resolved branch
//   EXE_Taken        in   actual direction
//   EXE_Target       in   actual target
//   EXE_PredTaken    in   prediction made for this branch in IF
//   PerfBranches     out  resolved branch count
//   PerfMispredicts  out  mispredicted branch count
// -----------------------------------------------------------------------------
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IF_PC,
   output logic        IF_Hit,
   output logic        IF_PredTaken,
   output logic [31:0] IF_PredTarget,
   input  logic        EXE_Update,
   input  logic [31:0] EXE_PC,
   input  logic        EXE_Taken,
   input  logic [31:0] EXE_Target,
   input  logic        EXE_PredTaken,
   output logic [31:0] PerfBranches,
   output logic [31:0] PerfMispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);

   // ---------------------------------------------------------------------------
   // Entry array (flops: lookup is asynchronous and reset clears every entry)
   // ---------------------------------------------------------------------------
   btb_entry_t table_q [ENTRIES];

   // ---------------------------------------------------------------------------
   // Fetch-side lookup
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] if_idx;
   btb_tag_t         if_tag;
   btb_entry_t       if_entry;

   assign if_idx   = IF_PC[IDX_W+1:2];
   assign if_tag   = btb_tag_t'(IF_PC[IDX_W+TAG_W+1:IDX_W+2]);
   assign if_entry = table_q[if_idx];

   assign IF_Hit        = if_entry.valid && (if_entry.tag == if_tag);
   assign IF_PredTaken  = IF_Hit && if_entry.ctr[1];
   assign IF_PredTarget = IF_PredTaken ? if_entry.target : IF_PC + 32'd4;

   // ---------------------------------------------------------------------------
   // EXE-side training
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] exe_idx;
   btb_tag_t         exe_tag;
   btb_entry_t       exe_entry;
   logic             exe_hit;
   btb_entry_t       entry_d;
   logic             entry_we;

   assign exe_idx   = EXE_PC[IDX_W+1:2];
   assign exe_tag   = btb_tag_t'(EXE_PC[IDX_W+TAG_W+1:IDX_W+2]);
   assign exe_entry = table_q[exe_idx];
   assign exe_hit   = exe_entry.valid && (exe_entry.tag == exe_tag);

   // NOTE: every always_comb output gets a default before any branching;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      entry_d  = exe_entry;
      entry_we = 1'b0;
      if (EXE_Update) begin
         if (exe_hit) begin
            entry_we    = 1'b1;
            entry_d.ctr = ctr_next(exe_entry.ctr, EXE_Taken);
            if (EXE_Taken) begin
               entry_d.target = EXE_Target;
            end
         end else if (EXE_Taken) begin
            // Taken miss allocates, evicting whatever alias held this slot.
            entry_we       = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = exe_tag;
            entry_d.target = EXE_Target;
            entry_d.ctr    = CTR_WT;
         end
      end
   end

   // NOTE: this array must be reset entry by entry because stale valid bits
   // would produce false hits; that is also why it cannot map onto block RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= BTB_ENTRY_RESET;
         end
      end else if (entry_we) begin
         table_q[exe_idx] <= entry_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic mispredict;

   assign mispredict = EXE_Update && (EXE_Taken != EXE_PredTaken);

   bpu_perf_counter u_perf_branches (
      .clk     (clk),
      .clr_i   (rst),
      .en_i    (EXE_Update),
      .count_o (PerfBranches)
   );

   bpu_perf_counter u_perf_mispredicts (
      .clk     (clk),
      .clr_i   (rst),
      .en_i    (mispredict),
      .count_o (PerfMispredicts)
   );

   // Byte-offset bits and bits above the tag take no part in lookup.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{IF_PC, EXE_PC};

endmodule : branch_predictor

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch prediction unit: a direct-mapped branch target buffer with 2-bit saturating counters. It predicts direction and target for the PC currently in IF. It is trained by the resolved branch outcome coming back from the EXE stage, at the point where branch flushes are generated. It also keeps branch and mispredict performance counters.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥ 2; IDX_W = log2(ENTRIES).
- TAG_W, 8, stored tag bits; IDX_W + TAG_W + 2 ≤ 32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- IF_PC  in  32  fetch PC to predict.
- IF_Hit  out  1  valid entry with matching tag for IF_PC.
- IF_PredTaken  out  1  IF_Hit && counter MSB.
- IF_PredTarget  out  32  stored target if IF_PredTaken, else IF_PC + 4.
- EXE_Update  in  1  a branch instruction resolved in EXE this cycle (isBranch qualified).
- EXE_PC  in  32  PC of the resolved branch.
- EXE_Taken  in  1  actual direction.
- EXE_Target  in  32  actual target (meaningful when EXE_Taken).
- EXE_PredTaken  in  1  prediction carried down the pipe from IF for this branch.
- PerfBranches  out  32  count of EXE_Update cycles.
- PerfMispredicts  out  32  count of EXE_Update && (EXE_Taken != EXE_PredTaken).

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]. PC[1:0] ignored.
- Entry = {valid, tag, target[31:0], ctr[1:0]}. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup: purely combinational from entry array; IF_Hit = valid && tag match.
- Update when EXE_Update=1, entry at EXE index:
  - Tag hit, taken: ctr saturating +1 (ST stays ST); target ← EXE_Target.
  - Tag hit, not taken: ctr saturating −1 (SNT stays SNT); target unchanged.
  - Miss, taken: allocate valid=1, tag, target=EXE_Target, ctr=WT (replaces any alias).
  - Miss, not taken: no change.
- EXE_Update=0: table untouched, regardless of other EXE inputs.
- Perf counters are free-running 32-bit counters. They wrap 0xFFFFFFFF→0 and have no saturation.

## Timing
- Lookup latency 0 cycles; outputs track IF_PC and table state in the same cycle.
- An update written at edge N is visible to lookup from cycle N onward, i.e. the cycle after EXE_Update was presented.
- Same-cycle lookup and update of the same index: IF sees pre-update contents. There is no write-through bypass.
- Perf counters increment on the same edge as the table update. Their outputs are registered.
- Reset, rst=1 at an edge, takes priority over any concurrent update:
  - All valid ← 0, all ctr ← WNT, targets/tags ← 0, both perf counters ← 0.
  - After reset: IF_Hit=0, IF_PredTaken=0, IF_PredTarget=IF_PC+4, PerfBranches=0, PerfMispredicts=0.
- Reset mid-operation discards all training. An EXE_Update in the reset cycle is dropped and not counted.

## Structure
- Shared package holds:
  - Counter constants CTR_SNT/WNT/WT/ST.
  - BTB entry struct typedef.
  - A saturating next-counter function, so other predictors can reuse it.
- Entry array is a flop array, not BRAM, because lookup is asynchronous and reset clears every entry.
- One sub-module, bpu_perf_counter (32-bit, enable, sync clear), instantiated twice.

## Test plan
- Reset, then IF_PC=0xBFC00000 -> IF_Hit=0, IF_PredTaken=0, IF_PredTarget=0xBFC00004, both perf counters 0.
- Update PC=0x80000010, taken, target 0x80000100; next cycle IF_PC=0x80000010 -> Hit=1, PredTaken=1, PredTarget=0x80000100 (ctr WT).
- Counter saturation on PC=0x80000010:
  - Three not-taken updates -> WT→WNT→SNT→SNT; PredTaken=0, Hit=1, PredTarget=0x80000014.
  - Four taken updates -> SNT→WNT→WT→ST→ST.
- Aliasing, ENTRIES=16: after training 0x80000010, lookup 0x80000050 (same index, different tag) -> Hit=0.
  - Not-taken update at 0x80000050 leaves 0x80000010 still hitting.
  - Taken update to 0x80000200 replaces it; 0x80000010 then misses.
- Same-cycle update/lookup of 0x80000020 (first taken allocate) -> Hit=0 that cycle, Hit=1 next cycle.
- Perf counters and reset:
  - Updates (taken,pred 1), (taken,pred 0), (not,pred 0) -> PerfBranches=3, PerfMispredicts=1.
  - Force PerfBranches to 0xFFFFFFFF via 2^32−1 updates (or a backdoor force), one more update -> 0.
  - Assert rst together with a taken update -> table empty, counters 0, the update is not applied.
